// File: rtl/demux_2_buf.sv
// Buffered 1-to-2 demultiplexer: routes each accepted word by its select bit into
// one of two independent circular-buffer FIFOs, each drained by its own valid/ready port.

module demux_2_buf_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rdy,
  output logic [WIDTH-1:0] rdata,
  output logic             vld,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             pop;

  assign vld   = (level != '0);
  assign full  = (level == LW'(DEPTH));
  assign pop   = vld & rdy;
  assign rdata = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

module demux_2_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [LW-1:0]    a_level,
  output logic [LW-1:0]    b_level
);

  logic a_full;
  logic b_full;
  logic push_a;
  logic push_b;

  // Ready looks only at the selected FIFO's registered fill, never at the consumers.
  assign in_ready = in_sel ? ~b_full : ~a_full;
  assign push_a   = in_valid & in_ready & ~in_sel;
  assign push_b   = in_valid & in_ready &  in_sel;

  demux_2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .wdata (in_data),
    .rdy   (a_ready),
    .rdata (a_data),
    .vld   (a_valid),
    .full  (a_full),
    .level (a_level)
  );

  demux_2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .wdata (in_data),
    .rdy   (b_ready),
    .rdata (b_data),
    .vld   (b_valid),
    .full  (b_full),
    .level (b_level)
  );

endmodule

// File: tb/tb_demux_2_buf.sv
// Directed scoreboard bench for demux_2_buf: accepted words are queued per port and
// checked in order by an independent monitor as each port hands them out.

module tb_demux_2_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  a_level;
  logic [1:0]  b_level;

  int total = 0;
  int bad   = 0;
  int a_cnt = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  demux_2_buf #(.WIDTH(16), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_level  (a_level),
    .b_level  (b_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard input side: record every word the DUT accepts.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      if (in_sel) qb.push_back(in_data);
      else        qa.push_back(in_data);
    end
  end

  // Monitor: every handshake on an output must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && a_ready) begin
        a_cnt++;
        if (qa.size() == 0) chk("a_unexpected_word", {16'h0, a_data}, 32'hFFFF_FFFF);
        else                chk("a_order", {16'h0, a_data}, {16'h0, qa.pop_front()});
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) chk("b_unexpected_word", {16'h0, b_data}, 32'hFFFF_FFFF);
        else                chk("b_order", {16'h0, b_data}, {16'h0, qb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h1234;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset held while the producer is active
    repeat (3) step();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_b_level", b_level, 0);
    chk("rst_in_ready_a", in_ready, 1);
    in_sel = 1'b1;
    settle();
    chk("rst_in_ready_b", in_ready, 1);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    // Routing
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0001;
    step();
    in_sel = 1'b1; in_data = 16'h0002;
    settle();
    chk("route_a_data", a_data, 16'h0001);
    chk("route_a_valid", a_valid, 1);
    step();
    in_valid = 1'b0;
    settle();
    chk("route_b_data", b_data, 16'h0002);
    chk("route_a_level", a_level, 1);
    chk("route_b_level", b_level, 1);
    a_ready = 1'b1; b_ready = 1'b1;
    step();
    a_ready = 1'b0; b_ready = 1'b0;
    settle();
    chk("drain_a_level", a_level, 0);
    chk("drain_b_level", b_level, 0);

    // Full and back-pressure
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    in_data = 16'h0033;
    settle();
    chk("full_in_ready", in_ready, 0);
    chk("full_a_level", a_level, 2);
    in_sel = 1'b1; in_data = 16'h00BB;
    settle();
    chk("full_other_port_ready", in_ready, 1);
    step();
    in_sel = 1'b0; in_data = 16'h0033; a_ready = 1'b1;
    settle();
    chk("full_stall_while_pop", in_ready, 0);
    step();
    a_ready = 1'b0;
    settle();
    chk("after_pop_a_data", a_data, 16'h0022);
    chk("after_pop_in_ready", in_ready, 1);
    chk("after_pop_a_level", a_level, 1);
    chk("bb_b_data", b_data, 16'h00BB);
    step();
    in_valid = 1'b0;
    settle();
    chk("refill_a_level", a_level, 2);

    // Simultaneous push and pop
    a_ready = 1'b1; b_ready = 1'b1;
    step();
    a_ready = 1'b0; b_ready = 1'b0;
    settle();
    chk("pre_sim_a_level", a_level, 1);
    chk("pre_sim_b_level", b_level, 0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h00AA; a_ready = 1'b1;
    step();
    in_valid = 1'b0; a_ready = 1'b0;
    settle();
    chk("sim_a_level", a_level, 1);
    chk("sim_a_data", a_data, 16'h00AA);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    settle();
    chk("sim_drain_a_level", a_level, 0);

    // Wrap-around stream into B with toggling ready
    i = 0;
    for (int c = 0; c < 60 && (i < 8 || b_valid); c++) begin
      in_valid = (i < 8);
      in_sel   = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      b_ready  = (c % 2 == 0);
      settle();
      if (in_valid && in_ready) i++;
      chk("wrap_b_level_max", (b_level <= 2), 1);
      step();
    end
    in_valid = 1'b0; b_ready = 1'b0;
    settle();
    chk("wrap_all_accepted", i, 8);
    chk("wrap_all_delivered", qb.size(), 0);
    chk("wrap_b_level_end", b_level, 0);

    // Reset in the middle of operation
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0051;
    step();
    in_data = 16'h0052;
    step();
    in_sel = 1'b1; in_data = 16'h0061;
    step();
    in_valid = 1'b0;
    settle();
    chk("mid_a_level", a_level, 2);
    chk("mid_b_level", b_level, 1);
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    settle();
    chk("mid_rst_a_level", a_level, 0);
    chk("mid_rst_b_level", b_level, 0);
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    rst_n = 1'b1;
    step();
    a_cnt = 0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0F0F;
    step();
    in_valid = 1'b0;
    settle();
    chk("post_rst_a_data", a_data, 16'h0F0F);
    chk("post_rst_a_level", a_level, 1);
    a_ready = 1'b1;
    repeat (3) step();
    a_ready = 1'b0;
    settle();
    chk("post_rst_sole_word", a_cnt, 1);
    chk("post_rst_a_level_end", a_level, 0);
    chk("post_rst_b_valid", b_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_2_buf.md
# demux_2_buf

Buffered 1-to-2 demultiplexer for 16-bit datapath words: the inverse of the 2:1 operand mux. It accepts one word per cycle on a valid/ready input port and routes it, by a per-word select bit, into one of two independent output FIFOs (port A for `in_sel`=0, port B for `in_sel`=1). Each output drains under its own valid/ready handshake. It sits between a result producer and two consumers, for example a write-back path and a store path.

## Interface
- `WIDTH`, 16, data width in bits.
- `DEPTH`, 2, entries per output FIFO; a power of two, ≥ 2.
- `LW`, $clog2(DEPTH)+1, width of the fill-level outputs; derived, never overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  word to route.
- `in_sel`  in  1  destination: 0 routes to A, 1 routes to B.
- `in_valid`  in  1  `in_data`/`in_sel` are valid.
- `in_ready`  out  1  the word is accepted this cycle if `in_valid` is also 1.
- `a_data`  out  WIDTH  head word of FIFO A.
- `a_valid`  out  1  FIFO A is non-empty.
- `a_ready`  in  1  consumer A takes the head word.
- `b_data`, `b_valid`, `b_ready`: same as the A signals, for FIFO B.
- `a_level`  out  LW  FIFO A occupancy, 0..DEPTH.
- `b_level`  out  LW  FIFO B occupancy, 0..DEPTH.

## Operation
- Each FIFO is a circular buffer of DEPTH×WIDTH registers with a write pointer, a read pointer ($clog2(DEPTH) bits each, wrapping naturally from DEPTH-1 to 0) and an occupancy counter (LW bits).
- `in_ready` = NOT full(selected FIFO), where full means level == DEPTH. It depends combinationally on `in_sel` and registered state only, never on `a_ready`/`b_ready`. There is no pop-through into a full FIFO.
- Push into X: occurs when `in_valid` & `in_ready` and `in_sel` selects X. It writes `in_data` at wptr_X and increments wptr_X.
- Pop from X: occurs when `X_valid` & `X_ready`. It increments rptr_X.
- Level update per FIFO: push only +1; pop only -1; both at once, level unchanged; neither, unchanged.
- Simultaneous push and pop on the same FIFO is legal whenever the FIFO is not full. The word at the old head leaves and the new word is appended.
- A push into A and a pop from B in the same cycle are fully independent. Likewise for a push into B and a pop from A.
- `X_valid` = (level_X != 0). `X_data` = mem_X[rptr_X], driven from registers. When `X_valid`=0, `X_data` is the stale head value; consumers must not sample it.
- Ordering: words are delivered in arrival order within each port. No ordering is guaranteed across ports.
- No word is ever dropped or duplicated. A word with `in_valid`=1 and `in_ready`=0 must be held stable by the producer until accepted. Changing `in_sel` while stalled is the producer's responsibility and is not checked.
- Reset (asynchronous, any time, including mid-transfer): pointers=0, levels=0, so `a_valid`=`b_valid`=0, `a_level`=`b_level`=0, and `in_ready`=1 for either `in_sel`. Storage contents are cleared to 0, so `a_data`=`b_data`=0 after reset. All buffered words are discarded.
- There is no state machine beyond the two FIFO pointer/counter sets. The block has no idle or busy mode.

## Timing
- Latency: a word accepted at edge N appears on `X_data` with `X_valid`=1 after edge N (visible in cycle N+1), provided FIFO X was empty. Otherwise it appears after all earlier words in X have been popped.
- Throughput: one word per cycle in; one word per cycle out on each port, concurrently.
- A full FIFO stays stalled for the cycle in which it is popped. `in_ready` for that FIFO rises in the following cycle.
- Reset assertion takes effect immediately, without a clock. Deassertion is synchronous to the first `clk` edge after `rst_n` returns high.

## Test plan
- Reset: hold `rst_n`=0 while `in_valid`=1 and clocks toggle. Require `a_valid`=`b_valid`=0, `a_level`=`b_level`=0, `in_ready`=1, `a_data`=`b_data`=0. Then release reset.
- Routing: push 0x0001 (sel=0), then 0x0002 (sel=1), with `a_ready`=`b_ready`=0. Require `a_data`=0x0001 and `b_data`=0x0002 one cycle after each push, `a_level`=1 and `b_level`=1.
- Full and back-pressure: with `a_ready`=0, push 0x0011, 0x0022, then 0x0033 to A. The third push requires `in_ready`=0 and `a_level`=2. Meanwhile a sel=1 word of 0x00BB is accepted at once. Raise `a_ready` for one cycle: `a_data` becomes 0x0022 and `in_ready` (sel=0) returns to 1 in the next cycle. 0x0033 is then accepted.
- Simultaneous push and pop: with `a_level`=1, push 0x00AA to A while `a_ready`=1. Require `a_level` to stay at 1 and `a_data`=0x00AA afterwards.
- Wrap-around and order: stream 0x0100..0x0107 to B with `b_ready` toggling 1,0,1,0,… Require B to output exactly 0x0100..0x0107 in order, with no loss or duplication and `b_level` never above 2.
- Reset mid-operation: with `a_level`=2 and `b_level`=1, pulse `rst_n` low between edges. Require both levels to read 0 and both valids to read 0 immediately. After release, a push of 0x0F0F to A is output as the sole word.
